// File: rtl/phy_tx_scheduler.sv
// PHY transmit sequencer: one free-running 5-bit counter drives f/2f/4f tick strobes,
// a byte-per-4f serializer (MSB first at 32f) and the OFF -> SYNC -> ACTIVE bring-up.
module phy_tx_scheduler #(
    parameter int         SYNC_BYTES = 4,
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDL        = 8'h7C
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       enable,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       data_accept,
    output logic       tick_f,
    output logic       tick_2f,
    output logic       tick_4f,
    output logic       serial_out,
    output logic       link_active
);

    typedef enum logic [1:0] {OFF, SYNC, ACTIVE} state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES);

    state_t     state, state_next;
    logic [4:0] cnt;
    logic [3:0] sync_cnt, sync_cnt_next;
    logic [7:0] sh, load_byte;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) cnt <= 5'd0;
        else       cnt <= cnt + 5'd1;
    end

    // Strobes are decoded from the registered count and forced low during reset.
    always_comb begin
        tick_4f = ~reset & (cnt[2:0] == 3'd7);
        tick_2f = ~reset & (cnt[3:0] == 4'd15);
        tick_f  = ~reset & (cnt == 5'd31);
    end

    always_comb begin
        state_next    = state;
        sync_cnt_next = sync_cnt;
        load_byte     = 8'h00;
        data_accept   = 1'b0;
        if (tick_4f) begin
            case (state)
                OFF: begin
                    if (enable) begin
                        state_next    = SYNC;
                        sync_cnt_next = 4'd1;
                        load_byte     = COM;
                    end
                end
                SYNC: begin
                    if (!enable) begin
                        state_next    = OFF;
                        sync_cnt_next = 4'd0;
                    end else if (sync_cnt < SYNC_LAST) begin
                        sync_cnt_next = sync_cnt + 4'd1;
                        load_byte     = COM;
                    end else begin
                        // Last sync boundary already carries the first ACTIVE byte.
                        state_next  = ACTIVE;
                        load_byte   = valid_in ? data_in : IDL;
                        data_accept = valid_in;
                    end
                end
                ACTIVE: begin
                    if (!enable) begin
                        state_next    = OFF;
                        sync_cnt_next = 4'd0;
                    end else begin
                        load_byte   = valid_in ? data_in : IDL;
                        data_accept = valid_in;
                    end
                end
                default: begin
                    state_next    = OFF;
                    sync_cnt_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state       <= OFF;
            sync_cnt    <= 4'd0;
            link_active <= 1'b0;
        end else begin
            state       <= state_next;
            sync_cnt    <= sync_cnt_next;
            link_active <= (state_next == ACTIVE);
        end
    end

    // Loads land only on the boundary, so a byte in flight always completes.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset)        sh <= 8'h00;
        else if (tick_4f) sh <= load_byte;
        else              sh <= {sh[6:0], 1'b0};
    end

    assign serial_out = sh[7];

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: byte-level link model checked every cycle, plus
// literal expectations for bring-up, tick rates, data/idle bytes, disable and reset.
module tb_phy_tx_scheduler;

    localparam int         SYNC_BYTES = 4;
    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] IDL        = 8'h7C;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       enable  = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_accept, tick_f, tick_2f, tick_4f, serial_out, link_active;

    phy_tx_scheduler #(.SYNC_BYTES(SYNC_BYTES), .COM(COM), .IDL(IDL)) dut (
        .clk_32f(clk_32f), .reset(reset), .enable(enable), .valid_in(valid_in),
        .data_in(data_in), .data_accept(data_accept), .tick_f(tick_f),
        .tick_2f(tick_2f), .tick_4f(tick_4f), .serial_out(serial_out),
        .link_active(link_active)
    );

    always #5 clk_32f = ~clk_32f;

    int total = 0;
    int bad   = 0;

    // Link model: cycle position, bring-up phase, and the byte currently on the wire.
    int         m_cnt  = 0;
    int         m_mode = 0;   // 0 off, 1 sending COMs, 2 active
    int         m_coms = 0;
    logic [7:0] m_byte = 8'h00;

    logic ser_hist[$];
    logic link_hist[$];
    logic acc_hist[$];
    int   n_t4, n_t2, n_tf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = ser_hist[s+i];
        return b;
    endfunction

    // One cycle: drive inputs at the falling edge, compare, then advance the model.
    task automatic step(input logic en, input logic v, input logic [7:0] d);
        logic bnd, e_acc;
        enable = en; valid_in = v; data_in = d;
        #1;
        bnd   = (m_cnt % 8 == 7);
        e_acc = bnd && en && v && (m_mode == 2 || (m_mode == 1 && m_coms == SYNC_BYTES));
        chk("tick_4f", tick_4f, bnd);
        chk("tick_2f", tick_2f, (m_cnt % 16 == 15));
        chk("tick_f", tick_f, (m_cnt == 31));
        chk("serial_out", serial_out, m_byte[7 - (m_cnt % 8)]);
        chk("link_active", link_active, (m_mode == 2));
        chk("data_accept", data_accept, e_acc);
        ser_hist.push_back(serial_out);
        link_hist.push_back(link_active);
        acc_hist.push_back(data_accept);
        n_t4 += int'(tick_4f); n_t2 += int'(tick_2f); n_tf += int'(tick_f);
        if (bnd) begin
            if (!en) begin
                m_mode = 0; m_coms = 0; m_byte = 8'h00;
            end else if (m_mode == 0) begin
                m_mode = 1; m_coms = 1; m_byte = COM;
            end else if (m_mode == 1 && m_coms < SYNC_BYTES) begin
                m_coms++; m_byte = COM;
            end else begin
                m_mode = 2; m_byte = v ? d : IDL;
            end
        end
        m_cnt = (m_cnt + 1) % 32;
        @(negedge clk_32f);
    endtask

    task automatic run_n(input int n, input logic en, input logic v, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(en, v, d);
    endtask

    task automatic align(input int c, input logic en, input logic v, input logic [7:0] d);
        int n = 0;
        while (m_cnt != c && n < 40) begin step(en, v, d); n++; end
        chk("align_reached", m_cnt, c);
    endtask

    // Called at a falling edge; reset lands mid-cycle, release lines up with cycle 0.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_serial", serial_out, 1'b0);
        chk("rst_link", link_active, 1'b0);
        chk("rst_ticks", {tick_f, tick_2f, tick_4f}, 3'b000);
        m_cnt = 0; m_mode = 0; m_coms = 0; m_byte = 8'h00;
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        ser_hist.delete(); link_hist.delete(); acc_hist.delete();
    endtask

    task automatic bringup_literals();
        run_n(48, 1'b1, 1'b0, 8'h00);
        chk("t1_pre_byte", byte_at(0), 8'h00);
        for (int k = 0; k < 4; k++) chk("t1_com_byte", byte_at(8 + 8 * k), 8'hBC);
        chk("t1_first_idl", byte_at(40), 8'h7C);
        chk("t1_link_c39", link_hist[39], 1'b0);
        chk("t1_link_c40", link_hist[40], 1'b1);
    endtask

    initial begin
        int s, acc_n;
        @(negedge clk_32f);
        do_reset();

        // Bring-up with idle upstream.
        bringup_literals();

        // Tick rates over 64 cycles.
        n_t4 = 0; n_t2 = 0; n_tf = 0;
        run_n(64, 1'b1, 1'b0, 8'h00);
        chk("cnt_tick_4f", n_t4, 8);
        chk("cnt_tick_2f", n_t2, 4);
        chk("cnt_tick_f", n_tf, 2);

        // Held A5 data then idle.
        align(0, 1'b1, 1'b0, 8'h00);
        s = ser_hist.size();
        run_n(24, 1'b1, 1'b1, 8'hA5);
        run_n(16, 1'b1, 1'b0, 8'h00);
        acc_n = 0;
        for (int i = s; i < s + 24; i++) acc_n += int'(acc_hist[i]);
        chk("a5_accepts", acc_n, 3);
        chk("a5_byte1", byte_at(s + 8), 8'hA5);
        chk("a5_byte3", byte_at(s + 24), 8'hA5);
        chk("a5_then_idl", byte_at(s + 32), 8'h7C);

        // Disable mid-byte, then re-enable.
        align(3, 1'b1, 1'b0, 8'h00);
        s = ser_hist.size();
        run_n(13, 1'b0, 1'b0, 8'h00);
        chk("dis_inflight", byte_at(s - 3), 8'h7C);
        chk("dis_link_bnd", link_hist[s + 4], 1'b1);
        chk("dis_link_fall", link_hist[s + 5], 1'b0);
        chk("dis_zero_byte", byte_at(s + 5), 8'h00);
        run_n(48, 1'b1, 1'b0, 8'h00);

        // First ACTIVE byte taken at the last SYNC boundary.
        @(negedge clk_32f); // keep alignment: do_reset expects a falling edge
        do_reset();
        run_n(39, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        run_n(8, 1'b1, 1'b0, 8'h00);
        chk("sync_accept", acc_hist[39], 1'b1);
        chk("first_active_3c", byte_at(40), 8'h3C);

        // Reset at cnt=3 while ACTIVE, then repeat bring-up.
        align(3, 1'b1, 1'b0, 8'h00);
        chk("pre_rst_link", link_active, 1'b1);
        do_reset();
        bringup_literals();

        // Randomized traffic with occasional disables and one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 90), $urandom_range(0, 1), 8'($urandom));
            if (i == 700) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
